// File: rtl/la_acq_if.sv
// ============================================================================
// la_acq_if : stream bus of the acquisition gate (input sti_*, output sto_*)
// Revision  : 1.0
// ============================================================================
`default_nettype none

interface la_acq_if #(
    parameter int DW = 16
);
    logic [DW-1:0] sti_tdata;
    logic          sti_tvalid;
    logic          sti_tready;
    logic [DW-1:0] sto_tdata;
    logic          sto_tvalid;
    logic          sto_tlast;
    logic          sto_tready;

    // slave: the acquisition block; master: whatever feeds and drains it
    modport slave (
        input  sti_tdata, sti_tvalid,
        output sti_tready,
        output sto_tdata, sto_tvalid, sto_tlast,
        input  sto_tready
    );

    modport master (
        output sti_tdata, sti_tvalid,
        input  sti_tready,
        input  sto_tdata, sto_tvalid, sto_tlast,
        output sto_tready
    );
endinterface

`default_nettype wire

// File: rtl/la_acq.sv
// ============================================================================
// la_acq : logic-analyser acquisition gate (pre-trigger, arm, post-trigger)
// Revision : 1.0
// ============================================================================
`default_nettype none

module la_acq #(
    parameter int DW = 16,
    parameter int CW = 32
) (
    input  wire logic          clk,
    input  wire logic          ctl_rst,
    input  wire logic          ctl_acq,
    input  wire logic          ctl_stp,
    input  wire logic [CW-1:0] cfg_pre,
    input  wire logic [CW-1:0] cfg_pst,
    input  wire logic          trg,
    la_acq_if.slave            st,
    output logic               sts_run,
    output logic               sts_arm,
    output logic               sts_don,
    output logic [CW-1:0]      sts_pre,
    output logic [CW-1:0]      sts_pst
);

    localparam logic [CW-1:0] c_one = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        ARM  = 2'd2,
        PST  = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_pre;
    logic [CW-1:0] r_pst;
    logic          r_don;

    logic          w_active;
    logic          w_ready;
    logic          w_valid;
    logic          w_xfer;
    logic [DW-1:0] w_data;
    logic [CW-1:0] w_pre_inc;
    logic [CW-1:0] w_pst_inc;
    logic          w_fin_arm;
    logic          w_fin_pst;

    // Zero-latency pass-through while acquiring; IDLE swallows the input
    assign w_active      = (r_state != IDLE);
    assign w_ready       = w_active ? st.sto_tready : 1'b1;
    assign w_valid       = w_active & st.sti_tvalid;
    assign w_xfer        = st.sti_tvalid & w_ready;
    assign w_data        = st.sti_tdata;

    assign st.sti_tready = w_ready;
    assign st.sto_tvalid = w_valid;
    assign st.sto_tdata  = w_data;

    assign w_pre_inc = (&r_pre) ? r_pre : (r_pre + c_one);
    assign w_pst_inc = r_pst + c_one;

    // tlast follows the presented word so it is stable while stalled
    assign w_fin_arm    = (r_state == ARM) & trg & (cfg_pst == '0);
    assign w_fin_pst    = (r_state == PST) & (w_pst_inc == cfg_pst);
    assign st.sto_tlast = w_valid & (w_fin_arm | w_fin_pst);

    always_ff @(posedge clk) begin
        if (ctl_rst) begin
            r_state <= IDLE;
            r_pre   <= '0;
            r_pst   <= '0;
            r_don   <= 1'b0;
        end else begin
            r_don <= 1'b0;
            if (ctl_stp) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (ctl_acq) begin
                            r_state <= PRE;
                            r_pre   <= '0;
                            r_pst   <= '0;
                        end
                    end
                    PRE: begin
                        if (w_xfer) begin
                            r_pre <= w_pre_inc;
                        end
                        if ((cfg_pre == '0) || (w_xfer && (w_pre_inc == cfg_pre))) begin
                            r_state <= ARM;
                        end
                    end
                    ARM: begin
                        if (w_xfer) begin
                            r_pre <= w_pre_inc;
                            if (trg) begin
                                if (cfg_pst == '0) begin
                                    r_state <= IDLE;
                                    r_don   <= 1'b1;
                                end else begin
                                    r_state <= PST;
                                end
                            end
                        end
                    end
                    PST: begin
                        if (w_xfer) begin
                            r_pst <= w_pst_inc;
                            if (w_pst_inc == cfg_pst) begin
                                r_state <= IDLE;
                                r_don   <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign sts_run = (r_state != IDLE);
    assign sts_arm = (r_state == ARM);
    assign sts_don = r_don;
    assign sts_pre = r_pre;
    assign sts_pst = r_pst;

endmodule

`default_nettype wire

// File: tb/tb_la_acq.sv
// ============================================================================
// tb_la_acq : directed scoreboard bench for la_acq
// Revision  : 1.0
// ============================================================================
`default_nettype none

module tb_la_acq;
    localparam int DW = 16;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          ctl_rst, ctl_acq, ctl_stp, trg;
    logic [CW-1:0] cfg_pre, cfg_pst;
    logic          sts_run, sts_arm, sts_don;
    logic [CW-1:0] sts_pre, sts_pst;

    always #5 clk = ~clk;

    la_acq_if #(.DW(DW)) bus ();

    la_acq #(.DW(DW), .CW(CW)) dut (
        .clk     (clk),
        .ctl_rst (ctl_rst),
        .ctl_acq (ctl_acq),
        .ctl_stp (ctl_stp),
        .cfg_pre (cfg_pre),
        .cfg_pst (cfg_pst),
        .trg     (trg),
        .st      (bus),
        .sts_run (sts_run),
        .sts_arm (sts_arm),
        .sts_don (sts_don),
        .sts_pre (sts_pre),
        .sts_pst (sts_pst)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   don_cnt  = 0;
    bit   toggle_en = 1'b0;

    task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one word; push its expected output if the DUT should forward it
    task automatic send(input logic [DW-1:0] d, input logic t, input bit out, input bit last);
        bit   done;
        exp_t e;
        done = 1'b0;
        bus.sti_tdata  = d;
        bus.sti_tvalid = 1'b1;
        trg            = t;
        if (out) begin
            e.d = d;
            e.l = last;
            sb.push_back(e);
        end
        for (int i = 0; i < 50 && !done; i++) begin
            if (toggle_en) bus.sto_tready = ~bus.sto_tready;
            @(negedge clk);
            done = bus.sti_tready;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %0h not accepted within 50 cycles", d);
        end
        bus.sti_tvalid = 1'b0;
        trg            = 1'b0;
    endtask

    task automatic start_acq();
        ctl_acq = 1'b1;
        cyc();
        ctl_acq = 1'b0;
    endtask

    // Monitor: pops expectations on every output handshake, tracks sts_don timing
    initial begin
        exp_t e;
        bit   don_exp;
        don_exp = 1'b0;
        forever begin
            @(negedge clk);
            if (don_exp || sts_don === 1'b1) begin
                checks++;
                if (sts_don !== don_exp) begin
                    errors++;
                    $display("FAIL sts_don: got %b expected %b", sts_don, don_exp);
                end
            end
            if (sts_don === 1'b1) don_cnt++;
            don_exp = 1'b0;
            if (bus.sto_tvalid === 1'b1 && bus.sto_tready === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: data %0h last %b", bus.sto_tdata, bus.sto_tlast);
                end else begin
                    e = sb.pop_front();
                    if (bus.sto_tdata !== e.d || bus.sto_tlast !== e.l) begin
                        errors++;
                        $display("FAIL output: got data %0h last %b expected data %0h last %b",
                                 bus.sto_tdata, bus.sto_tlast, e.d, e.l);
                    end
                    don_exp = e.l && !ctl_stp && !ctl_rst;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ctl_rst = 1'b1; ctl_acq = 1'b0; ctl_stp = 1'b0; trg = 1'b0;
        cfg_pre = '0; cfg_pst = '0;
        bus.sti_tdata = '0; bus.sti_tvalid = 1'b0; bus.sto_tready = 1'b1;
        repeat (3) cyc();

        // Reset state, with a valid word presented
        bus.sti_tvalid = 1'b1;
        #1;
        chk("rst_run",    sts_run, 0);
        chk("rst_arm",    sts_arm, 0);
        chk("rst_pre",    sts_pre, 0);
        chk("rst_pst",    sts_pst, 0);
        chk("rst_don",    sts_don, 0);
        chk("rst_tvalid", bus.sto_tvalid, 0);
        chk("rst_tlast",  bus.sto_tlast, 0);
        chk("rst_tready", bus.sti_tready, 1);
        bus.sti_tvalid = 1'b0;
        ctl_rst = 1'b0;
        cyc();
        send(16'hDEAD, 1'b1, 1'b0, 1'b0);
        chk("idle_discard_run", sts_run, 0);

        // pre=4, pst=3, trigger always high
        cfg_pre = 4; cfg_pst = 3;
        start_acq();
        chk("a_run", sts_run, 1);
        chk("a_pre0", sts_pre, 0);
        for (int i = 1; i <= 4; i++) send(DW'(16'h0100 + i), 1'b1, 1'b1, 1'b0);
        chk("a_arm", sts_arm, 1);
        chk("a_pre4", sts_pre, 4);
        send(16'h0105, 1'b1, 1'b1, 1'b0);
        chk("a_pst_state", {sts_run, sts_arm}, 2'b10);
        chk("a_pre5", sts_pre, 5);
        send(16'h0106, 1'b1, 1'b1, 1'b0);
        send(16'h0107, 1'b1, 1'b1, 1'b0);
        send(16'h0108, 1'b1, 1'b1, 1'b1);
        chk("a_done_run", sts_run, 0);
        chk("a_pre_final", sts_pre, 5);
        chk("a_pst_final", sts_pst, 3);
        cyc();
        chk("a_don_cnt", don_cnt, 1);

        // early triggers in PRE ignored, pst=0
        cfg_pre = 2; cfg_pst = 0;
        start_acq();
        send(16'h0201, 1'b1, 1'b1, 1'b0);
        send(16'h0202, 1'b1, 1'b1, 1'b0);
        chk("b_arm", sts_arm, 1);
        send(16'h0203, 1'b0, 1'b1, 1'b0);
        send(16'h0204, 1'b0, 1'b1, 1'b0);
        send(16'h0205, 1'b0, 1'b1, 1'b0);
        chk("b_still_arm", sts_arm, 1);
        send(16'h0206, 1'b1, 1'b1, 1'b1);
        chk("b_run", sts_run, 0);
        chk("b_pre", sts_pre, 6);
        chk("b_pst", sts_pst, 0);
        cyc();
        chk("b_don_cnt", don_cnt, 2);

        // pre=0 arms without a transfer; 50% backpressure
        cfg_pre = 0; cfg_pst = 2;
        start_acq();
        cyc();
        chk("c_arm", sts_arm, 1);
        chk("c_pre0", sts_pre, 0);
        toggle_en = 1'b1;
        send(16'h0301, 1'b0, 1'b1, 1'b0);
        send(16'h0302, 1'b1, 1'b1, 1'b0);
        send(16'h0303, 1'b0, 1'b1, 1'b0);
        send(16'h0304, 1'b0, 1'b1, 1'b1);
        toggle_en = 1'b0;
        bus.sto_tready = 1'b1;
        chk("c_run", sts_run, 0);
        chk("c_pre", sts_pre, 2);
        chk("c_pst", sts_pst, 2);
        cyc();
        chk("c_don_cnt", don_cnt, 3);

        // abort in PST with pst=1
        cfg_pre = 1; cfg_pst = 3;
        start_acq();
        send(16'h0401, 1'b0, 1'b1, 1'b0);
        send(16'h0402, 1'b1, 1'b1, 1'b0);
        send(16'h0403, 1'b0, 1'b1, 1'b0);
        chk("d_pst1", sts_pst, 1);
        ctl_stp = 1'b1;
        cyc();
        ctl_stp = 1'b0;
        chk("d_run", sts_run, 0);
        chk("d_pst_hold", sts_pst, 1);
        chk("d_pre_hold", sts_pre, 2);
        bus.sti_tvalid = 1'b1;
        #1;
        chk("d_idle_tvalid", bus.sto_tvalid, 0);
        bus.sti_tvalid = 1'b0;
        cyc();
        chk("d_don_cnt", don_cnt, 3);

        // abort coinciding with a completing trigger transfer
        cfg_pre = 1; cfg_pst = 0;
        start_acq();
        send(16'h0501, 1'b0, 1'b1, 1'b0);
        ctl_stp = 1'b1;
        send(16'h0502, 1'b1, 1'b1, 1'b1);
        ctl_stp = 1'b0;
        chk("e_run", sts_run, 0);
        chk("e_pre_hold", sts_pre, 1);
        cyc();
        chk("e_don_cnt", don_cnt, 3);

        // acq and stp together in IDLE
        ctl_acq = 1'b1; ctl_stp = 1'b1;
        cyc();
        ctl_acq = 1'b0; ctl_stp = 1'b0;
        chk("f_acq_stp_run", sts_run, 0);

        // acq ignored in ARM, then reset during ARM
        cfg_pre = 1; cfg_pst = 1;
        start_acq();
        send(16'h0601, 1'b0, 1'b1, 1'b0);
        start_acq();
        chk("f_arm", sts_arm, 1);
        chk("f_pre_kept", sts_pre, 1);
        ctl_rst = 1'b1;
        cyc();
        ctl_rst = 1'b0;
        chk("f_rst_run", sts_run, 0);
        chk("f_rst_arm", sts_arm, 0);
        chk("f_rst_pre", sts_pre, 0);
        chk("f_rst_pst", sts_pst, 0);
        chk("f_rst_don", sts_don, 0);
        chk("f_rst_tready", bus.sti_tready, 1);
        bus.sti_tvalid = 1'b1;
        #1;
        chk("f_rst_tvalid", bus.sto_tvalid, 0);
        chk("f_rst_tlast", bus.sto_tlast, 0);
        bus.sti_tvalid = 1'b0;

        repeat (3) cyc();
        chk("sb_empty", sb.size(), 0);
        chk("don_total", don_cnt, 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/la_acq.md
LA_ACQ -- requirements
Module: la_acq

Interface
REQ-001 Parameter DW, default 16, stream data width in bits.
REQ-002 Parameter CW, default 32, pre/post-trigger counter width in bits.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 ctl_rst  in  1  reset, synchronous, active-high.
REQ-005 ctl_acq  in  1  start acquisition (single-cycle pulse).
REQ-006 ctl_stp  in  1  abort acquisition (single-cycle pulse).
REQ-007 cfg_pre  in  CW  number of pre-trigger transfers required before arming.
REQ-008 cfg_pst  in  CW  number of transfers following the trigger transfer.
REQ-009 trg  in  1  trigger flag, aligned with the current sti transfer (from the trigger stage).
REQ-010 sti_tdata  in  DW  input stream data.
REQ-011 sti_tvalid  in  1  input stream valid.
REQ-012 sti_tready  out  1  input stream ready.
REQ-013 sto_tdata  out  DW  output stream data.
REQ-014 sto_tvalid  out  1  output stream valid.
REQ-015 sto_tlast  out  1  marks the final transfer of an acquisition.
REQ-016 sto_tready  in  1  output stream ready.
REQ-017 sts_run  out  1  high while state is not IDLE.
REQ-018 sts_arm  out  1  high in state ARM.
REQ-019 sts_don  out  1  one-cycle pulse when an acquisition completes with TLAST.
REQ-020 sts_pre  out  CW  pre-trigger transfer counter.
REQ-021 sts_pst  out  CW  post-trigger transfer counter.

Function
REQ-022 States SHALL be IDLE, PRE, ARM, PST; "transfer" SHALL mean sti_tvalid & sti_tready in that cycle.
REQ-023 In IDLE: sti_tready=1, sto_tvalid=0, input data discarded; in PRE/ARM/PST: sto_tvalid=sti_tvalid, sti_tready=sto_tready, sto_tdata=sti_tdata (zero latency, combinational path).
REQ-024 IDLE->PRE on ctl_acq=1 & ctl_stp=0; sts_pre and sts_pst SHALL clear to 0 on that edge.
REQ-025 ctl_acq outside IDLE SHALL be ignored.
REQ-026 PRE: each transfer increments sts_pre; PRE->ARM on the edge where the incremented value equals cfg_pre; cfg_pre=0 SHALL go PRE->ARM on the next clock without requiring a transfer.
REQ-027 trg SHALL be ignored in IDLE and PRE and in any cycle without a transfer.
REQ-028 ARM: sts_pre keeps incrementing per transfer, saturating at all-ones; a transfer with trg=1 moves ARM->PST, and that transfer is the trigger transfer.
REQ-029 If cfg_pst=0, the trigger transfer SHALL carry sto_tlast=1 and the FSM SHALL go ARM->IDLE directly.
REQ-030 PST: each transfer increments sts_pst; the transfer on which the incremented value equals cfg_pst SHALL carry sto_tlast=1, then PST->IDLE.
REQ-031 sto_tlast SHALL be 0 whenever sto_tvalid=0 or no final transfer is presented.
REQ-032 sts_don SHALL pulse for one cycle, registered, on the cycle after the TLAST transfer.
REQ-033 ctl_stp in any state SHALL force IDLE on the next edge, with no TLAST and no sts_don; counters hold their values; ctl_stp has priority over ctl_acq and over a simultaneous completing transfer (that transfer still passes, with tlast=1 if it is final, but sts_don stays 0).
REQ-034 cfg_pre/cfg_pst SHALL be sampled continuously; changes during acquisition take effect on the next comparison.
REQ-035 Backpressure (sto_tready=0) SHALL stall counting; no transfer is lost or duplicated.

Reset
REQ-036 ctl_rst=1 at a clock edge SHALL force state IDLE, sts_pre=0, sts_pst=0, sts_don=0; ctl_rst has priority over ctl_acq/ctl_stp; mid-acquisition reset drops the acquisition with no TLAST.
REQ-037 After reset: sts_run=0, sts_arm=0, sto_tvalid=0, sto_tlast=0, sti_tready=1.

Verification
REQ-038 cfg_pre=4, cfg_pst=3, continuous valid, trg on every sample -> 4 PRE transfers, trigger on 5th transfer, TLAST on 8th transfer, sts_don pulse 1 cycle later, sts_pre=5, sts_pst=3.
REQ-039 cfg_pre=2, trg pulses on transfers 1 and 2, next on transfer 6 -> early triggers ignored, trigger on transfer 6, with cfg_pst=0 TLAST on transfer 6.
REQ-040 cfg_pre=0, cfg_pst=2, sto_tready toggling 50% -> exactly 3 output transfers from the trigger, data order preserved, TLAST on the last.
REQ-041 ctl_stp asserted in PST with sts_pst=1 -> IDLE next cycle, no TLAST, no sts_don, sts_pst holds 1.
REQ-042 ctl_acq and ctl_stp in the same cycle in IDLE -> remain IDLE; ctl_rst during ARM -> all status outputs return to reset values.
